// File: rtl/mips_mem_arb_pkg.sv
// Shared types and constants for the mips_mem_arbiter block.
package mips_mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_INSTR = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// CPU-side and memory-side signals of the arbiter bundled together.
// master: the arbiter's view (drives memory requests and CPU results).
// slave:  the environment's view (CPU requests and memory responses).
interface mips_mem_arbiter_if;
  import mips_mem_arb_pkg::*;

  logic [ADDR_W-1:0] instr_address;
  logic [DATA_W-1:0] instr_readdata;
  logic [ADDR_W-1:0] data_address;
  logic              data_read;
  logic              data_write;
  logic [DATA_W-1:0] data_writedata;
  logic [DATA_W-1:0] data_readdata;
  logic              clk_enable;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_ack;
  logic              arb_error;

  modport master (
    input  instr_address, data_address, data_read, data_write, data_writedata,
           mem_readdata, mem_ack,
    output instr_readdata, data_readdata, clk_enable, mem_address, mem_read,
           mem_write, mem_writedata, arb_error
  );

  modport slave (
    output instr_address, data_address, data_read, data_write, data_writedata,
           mem_readdata, mem_ack,
    input  instr_readdata, data_readdata, clk_enable, mem_address, mem_read,
           mem_write, mem_writedata, arb_error
  );

endinterface

// File: rtl/mips_mem_arb_wait_ctr.sv
// Loadable saturating up-counter with a limit compare.
// o_hit is high once the count has reached LIMIT-1, i.e. one more
// increment would make LIMIT cycles elapsed.
module mips_mem_arb_wait_ctr #(
  parameter int W     = 16,
  parameter int LIMIT = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_hit
);

  logic [W-1:0] r_count;

  // Clear on load, otherwise count up and stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
  assign o_hit   = (r_count >= W'(LIMIT - 1));

endmodule

// File: rtl/mips_mem_arbiter.sv
// Unified memory port arbiter for mips_cpu_harvard: serves the data access
// of each CPU step, then the instruction fetch, then releases the CPU for
// one clock through clk_enable.
// Optional build macro MIPS_MEM_ARB_STATS_EN adds step/stall/data counters.
module mips_mem_arbiter
  import mips_mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               reset,
  mips_mem_arbiter_if.master bus
`ifdef MIPS_MEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]   stat_steps,
  output logic [CNT_W-1:0]   stat_stall,
  output logic [CNT_W-1:0]   stat_data
`endif
);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic [DATA_W-1:0] r_instr_readdata;
  logic [DATA_W-1:0] r_data_readdata;
  logic              w_wait_load;
  logic              w_wait_inc;
  logic              w_wait_hit;
  logic [CNT_W-1:0]  w_wait_cnt;
  logic              w_unused_wait;

  // State register; reset drops any request immediately via the outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and Moore-style memory request / CPU strobe generation.
  always_comb begin
    w_state_next      = r_state;
    bus.mem_address   = '0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_writedata = '0;
    bus.clk_enable    = 1'b0;
    w_wait_inc        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.data_read && bus.data_write) begin
          w_state_next = ST_ERR;
        end else if (bus.data_read || bus.data_write) begin
          w_state_next = ST_DATA;
        end else begin
          w_state_next = ST_INSTR;
        end
      end
      ST_DATA: begin
        bus.mem_address   = bus.data_address;
        bus.mem_read      = bus.data_read;
        bus.mem_write     = bus.data_write;
        bus.mem_writedata = bus.data_writedata;
        if (bus.mem_ack) begin
          w_state_next = ST_INSTR;
        end else begin
          w_wait_inc = 1'b1;
          if (w_wait_hit) w_state_next = ST_ERR;
        end
      end
      ST_INSTR: begin
        bus.mem_address = bus.instr_address;
        bus.mem_read    = 1'b1;
        if (bus.mem_ack) begin
          w_state_next = ST_DONE;
        end else begin
          w_wait_inc = 1'b1;
          if (w_wait_hit) w_state_next = ST_ERR;
        end
      end
      ST_DONE: begin
        bus.clk_enable = 1'b1;
        w_state_next   = ST_IDLE;
      end
      ST_ERR: begin
        w_state_next = ST_ERR;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Any state change restarts the wait count, so DATA/INSTR start from zero.
  assign w_wait_load = (w_state_next != r_state);

  mips_mem_arb_wait_ctr #(
    .W     (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_ctr (
    .clk     (clk),
    .rst_n   (reset),
    .i_load  (w_wait_load),
    .i_inc   (w_wait_inc),
    .o_count (w_wait_cnt),
    .o_hit   (w_wait_hit)
  );

  assign w_unused_wait = ^w_wait_cnt;

  // Capture read data on the ack cycle; stores leave load data untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_readdata <= '0;
      r_data_readdata  <= '0;
    end else begin
      if ((r_state == ST_DATA) && bus.mem_ack && bus.data_read) begin
        r_data_readdata <= bus.mem_readdata;
      end
      if ((r_state == ST_INSTR) && bus.mem_ack) begin
        r_instr_readdata <= bus.mem_readdata;
      end
    end
  end

  assign bus.instr_readdata = r_instr_readdata;
  assign bus.data_readdata  = r_data_readdata;
  assign bus.arb_error      = (r_state == ST_ERR);

`ifdef MIPS_MEM_ARB_STATS_EN
  // Index 0: completed steps, 1: stalled clocks, 2: data completions.
  logic [2:0]       w_stat_inc;
  logic [2:0]       w_stat_hit;
  logic [CNT_W-1:0] w_stat_cnt [3];
  logic             w_unused_stats;

  assign w_stat_inc[0] = (r_state == ST_DONE);
  assign w_stat_inc[1] = (r_state != ST_DONE) && (r_state != ST_ERR);
  assign w_stat_inc[2] = (r_state == ST_DATA) && bus.mem_ack;

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    mips_mem_arb_wait_ctr #(
      .W     (CNT_W),
      .LIMIT (1)
    ) u_stat_ctr (
      .clk     (clk),
      .rst_n   (reset),
      .i_load  (1'b0),
      .i_inc   (w_stat_inc[gi]),
      .o_count (w_stat_cnt[gi]),
      .o_hit   (w_stat_hit[gi])
    );
  end

  assign stat_steps     = w_stat_cnt[0];
  assign stat_stall     = w_stat_cnt[1];
  assign stat_data      = w_stat_cnt[2];
  assign w_unused_stats = ^w_stat_hit;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed self-checking bench for mips_mem_arbiter (TIMEOUT_CYCLES=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mips_mem_arbiter;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  mips_mem_arbiter_if bus_if ();

`ifdef MIPS_MEM_ARB_STATS_EN
  logic [15:0] stat_steps;
  logic [15:0] stat_stall;
  logic [15:0] stat_data;
`endif

  mips_mem_arbiter #(
    .TIMEOUT_CYCLES (8),
    .CNT_W          (16)
  ) dut (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus_if)
`ifdef MIPS_MEM_ARB_STATS_EN
    ,
    .stat_steps (stat_steps),
    .stat_stall (stat_stall),
    .stat_data  (stat_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus_if.instr_address  = 32'hbfc00000;
    bus_if.data_address   = 32'h0;
    bus_if.data_read      = 1'b0;
    bus_if.data_write     = 1'b0;
    bus_if.data_writedata = 32'h0;
    bus_if.mem_readdata   = 32'h24010020;
    bus_if.mem_ack        = 1'b0;

    // Reset state
    tick();
    check_eq("rst_rd", bus_if.mem_read, 1'b0);
    check_eq("rst_wr", bus_if.mem_write, 1'b0);
    check_eq("rst_addr", bus_if.mem_address, 32'h0);
    check_eq("rst_ce", bus_if.clk_enable, 1'b0);
    check_eq("rst_err", bus_if.arb_error, 1'b0);
    check_eq("rst_idata", bus_if.instr_readdata, 32'h0);
    reset_n = 1'b1;

    // Fetch-only, zero-wait: IDLE, INSTR, DONE
    tick();
    check_eq("f_rd", bus_if.mem_read, 1'b1);
    check_eq("f_addr", bus_if.mem_address, 32'hbfc00000);
    check_eq("f_ce0", bus_if.clk_enable, 1'b0);
    bus_if.mem_ack = 1'b1;
    tick();
    check_eq("f_ce", bus_if.clk_enable, 1'b1);
    check_eq("f_rd_drop", bus_if.mem_read, 1'b0);
    check_eq("f_idata", bus_if.instr_readdata, 32'h24010020);
    bus_if.mem_readdata = 32'h11111111;  // ack in DONE/IDLE must be ignored
    tick();
    check_eq("f_ce_off", bus_if.clk_enable, 1'b0);
    check_eq("f_idata_hold", bus_if.instr_readdata, 32'h24010020);
    $display("step fetch-only done");

    // Load with ack delayed two clocks
    bus_if.mem_ack      = 1'b0;
    bus_if.data_read    = 1'b1;
    bus_if.data_address = 32'h00000020;
    bus_if.mem_readdata = 32'hf0000000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("ld_rd", bus_if.mem_read, 1'b1);
      check_eq("ld_wr", bus_if.mem_write, 1'b0);
      check_eq("ld_addr", bus_if.mem_address, 32'h20);
      if (i == 2) bus_if.mem_ack = 1'b1;
    end
    tick();
    check_eq("ld_data", bus_if.data_readdata, 32'hf0000000);
    check_eq("ld_fetch_addr", bus_if.mem_address, 32'hbfc00000);
    check_eq("ld_fetch_rd", bus_if.mem_read, 1'b1);
    check_eq("ld_ce0", bus_if.clk_enable, 1'b0);
    bus_if.data_read    = 1'b0;
    bus_if.mem_readdata = 32'h8c020020;
    tick();
    check_eq("ld_ce", bus_if.clk_enable, 1'b1);
    check_eq("ld_idata", bus_if.instr_readdata, 32'h8c020020);
    bus_if.mem_ack = 1'b0;
    tick();
    check_eq("ld_ce_off", bus_if.clk_enable, 1'b0);
    $display("step load done");

    // Store, zero-wait
    bus_if.data_write     = 1'b1;
    bus_if.data_address   = 32'h00000040;
    bus_if.data_writedata = 32'hdeadbeef;
    bus_if.mem_readdata   = 32'h12345678;
    tick();
    check_eq("st_wr", bus_if.mem_write, 1'b1);
    check_eq("st_rd", bus_if.mem_read, 1'b0);
    check_eq("st_wdata", bus_if.mem_writedata, 32'hdeadbeef);
    check_eq("st_addr", bus_if.mem_address, 32'h40);
    bus_if.mem_ack = 1'b1;
    tick();
    check_eq("st_wr_drop", bus_if.mem_write, 1'b0);
    check_eq("st_ddata", bus_if.data_readdata, 32'hf0000000);
    check_eq("st_fetch_rd", bus_if.mem_read, 1'b1);
    bus_if.data_write   = 1'b0;
    bus_if.mem_readdata = 32'h3c1d8000;
    tick();
    check_eq("st_ce", bus_if.clk_enable, 1'b1);
    check_eq("st_idata", bus_if.instr_readdata, 32'h3c1d8000);
    bus_if.mem_ack = 1'b0;
    tick();
    $display("step store done");

    // Memory never acks: 8 clocks in INSTR, then ERR
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("to_rd", bus_if.mem_read, 1'b1);
      check_eq("to_err", bus_if.arb_error, 1'b0);
    end
    tick();
    check_eq("to_err_set", bus_if.arb_error, 1'b1);
    check_eq("to_rd_drop", bus_if.mem_read, 1'b0);
    $display("step timeout done");

    // Reset clears ERR; then illegal read+write request
    reset_n = 1'b0;
    #1;
    check_eq("to_rst_err", bus_if.arb_error, 1'b0);
    check_eq("to_rst_idata", bus_if.instr_readdata, 32'h0);
    bus_if.data_read  = 1'b1;
    bus_if.data_write = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("il_err", bus_if.arb_error, 1'b1);
    for (int i = 0; i < 20; i++) begin
      bus_if.mem_ack = (i % 2 == 1);
      tick();
      check_eq("il_err_hold", bus_if.arb_error, 1'b1);
      check_eq("il_ce", bus_if.clk_enable, 1'b0);
      check_eq("il_rd", bus_if.mem_read, 1'b0);
      check_eq("il_wr", bus_if.mem_write, 1'b0);
    end
    reset_n = 1'b0;
    #1;
    check_eq("il_rst_err", bus_if.arb_error, 1'b0);
    $display("step illegal request done");

    // Reset pulsed mid-DATA, then a normal fetch step
    bus_if.mem_ack        = 1'b0;
    bus_if.data_read      = 1'b0;
    bus_if.data_write     = 1'b1;
    bus_if.data_address   = 32'h00000080;
    bus_if.data_writedata = 32'hcafef00d;
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("rm_wr", bus_if.mem_write, 1'b1);
    check_eq("rm_addr", bus_if.mem_address, 32'h80);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rm_wr_async", bus_if.mem_write, 1'b0);
    check_eq("rm_addr_async", bus_if.mem_address, 32'h0);
    bus_if.data_write    = 1'b0;
    bus_if.instr_address = 32'h00000100;
    bus_if.mem_readdata  = 32'haabbccdd;
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("rm_fetch_rd", bus_if.mem_read, 1'b1);
    check_eq("rm_fetch_addr", bus_if.mem_address, 32'h100);
    check_eq("rm_wr_idle", bus_if.mem_write, 1'b0);
    bus_if.mem_ack = 1'b1;
    tick();
    check_eq("rm_ce", bus_if.clk_enable, 1'b1);
    check_eq("rm_idata", bus_if.instr_readdata, 32'haabbccdd);
    bus_if.mem_ack = 1'b0;
    $display("step reset mid-data done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
